// File: rtl/ser2par_frame_16_if.sv
// Handshake bundle between the serial frame source and the 16-bit load latch front end.
// The master side drives the serial stream. The slave side returns the word and status.
interface ser2par_frame_16_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sdata;
  logic             svalid;
  logic [WIDTH-1:0] pdata;
  logic             load;
  logic             busy;
  logic             frame_err;

  modport master (
    output start, sdata, svalid,
    input  pdata, load, busy, frame_err
  );

  modport slave (
    input  start, sdata, svalid,
    output pdata, load, busy, frame_err
  );
endinterface

// File: rtl/ser2par_frame_16.sv
// Serial-to-parallel framer. It assembles WIDTH framed bits and then presents them to a latch.
// The word is stable for one full cycle before a registered load strobe rises.
module ser2par_frame_16 #(
  parameter int WIDTH       = 16,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int LOAD_CYCLES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  ser2par_frame_16_if.slave  bus
);

  localparam int BIT_W  = $clog2(WIDTH + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int LOAD_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WIDTH - 1);
  localparam logic [IDLE_W-1:0] LAST_IDLE = IDLE_W'(TIMEOUT - 1);
  localparam logic [LOAD_W-1:0] LAST_LOAD = LOAD_W'(LOAD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    SETUP,
    LOAD
  } state_e;

  state_e             state_q,    state_d;
  logic [WIDTH-1:0]   shift_q,    shift_d;
  logic [BIT_W-1:0]   bitCnt_q,   bitCnt_d;
  logic [IDLE_W-1:0]  idleCnt_q,  idleCnt_d;
  logic [LOAD_W-1:0]  loadCnt_q,  loadCnt_d;
  logic [WIDTH-1:0]   pdata_q,    pdata_d;
  logic               load_q,     load_d;
  logic               frameErr_q, frameErr_d;
  logic [WIDTH-1:0]   shiftIn;

  generate
    if (MSB_FIRST) begin : g_msbFirst
      assign shiftIn = {shift_q[WIDTH-2:0], bus.sdata};
    end else begin : g_lsbFirst
      assign shiftIn = {bus.sdata, shift_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bitCnt_q   <= '0;
      idleCnt_q  <= '0;
      loadCnt_q  <= '0;
      pdata_q    <= '0;
      load_q     <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitCnt_q   <= bitCnt_d;
      idleCnt_q  <= idleCnt_d;
      loadCnt_q  <= loadCnt_d;
      pdata_q    <= pdata_d;
      load_q     <= load_d;
      frameErr_q <= frameErr_d;
    end
  end

  // In SHIFT, start outranks svalid. The bit that is on sdata during a restart is dropped.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitCnt_d   = bitCnt_q;
    idleCnt_d  = idleCnt_q;
    loadCnt_d  = loadCnt_q;
    pdata_d    = pdata_q;
    frameErr_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = SHIFT;
          shift_d   = '0;
          bitCnt_d  = '0;
          idleCnt_d = '0;
        end
      end

      SHIFT: begin
        if (bus.start) begin
          frameErr_d = 1'b1;
          shift_d    = '0;
          bitCnt_d   = '0;
          idleCnt_d  = '0;
        end else if (bus.svalid) begin
          shift_d   = shiftIn;
          bitCnt_d  = bitCnt_q + BIT_W'(1);
          idleCnt_d = '0;
          if (bitCnt_q == LAST_BIT) begin
            state_d = SETUP;
            pdata_d = shiftIn;
          end
        end else begin
          idleCnt_d = idleCnt_q + IDLE_W'(1);
          if (idleCnt_q == LAST_IDLE) begin
            state_d    = IDLE;
            frameErr_d = 1'b1;
          end
        end
      end

      SETUP: begin
        frameErr_d = bus.start;
        state_d    = LOAD;
        loadCnt_d  = '0;
      end

      LOAD: begin
        frameErr_d = bus.start;
        if (loadCnt_q == LAST_LOAD) begin
          state_d = IDLE;
        end else begin
          loadCnt_d = loadCnt_q + LOAD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Load comes from a flop because the downstream latch treats it as a clock.
  assign load_d = (state_d == LOAD);

  assign bus.pdata     = pdata_q;
  assign bus.load      = load_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.frame_err = frameErr_q;

endmodule
